cubehash_msg_ctrl: RTL and testbench

- Upstream feeder and sequencer for the CubeHash core.
- Accepts a byte message as a stream of 32-bit words and packs it into 256-bit blocks. Applies CubeHash padding.
- Drives the core's init/start/fetch/load handshake and returns the 256-bit digest on a valid/ready output port.
- Sits between the host bus adapter and the CubeHash core.

---
 rtl/cubehash_msg_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cubehash_msg_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cubehash_msg_ctrl.sv
// Message packer and handshake sequencer in front of the CubeHash core.
// Optional byte counter output msg_len is enabled with `define CUBEHASH_MSG_LEN_EN.
module cubehash_msg_ctrl #(
  parameter int         WORDS    = 8,
  parameter logic [7:0] PAD_BYTE = 8'h80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  input  logic                in_last,
  input  logic [1:0]          in_bytes,
  output logic                core_init,
  output logic                core_start,
  output logic [WORDS*32-1:0] core_msg,
  output logic                core_fetch,
  output logic                core_load,
  input  logic                core_busy,
  input  logic [WORDS*32-1:0] core_hash,
`ifdef CUBEHASH_MSG_LEN_EN
  output logic [63:0]         msg_len,
`endif
  output logic                out_valid,
  output logic [WORDS*32-1:0] out_hash,
  input  logic                out_ready
);
  localparam int CW = $clog2(WORDS);
  localparam int BW = WORDS * 32;

  typedef enum logic [2:0] {IDLE, INIT_W, FILL, ISSUE, RUN, FINAL, OUT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            wait_reg, wait_next;
  logic [BW-1:0]   buf_reg, buf_next;
  logic            final_reg, final_next;
  logic            pad_reg, pad_next;
  logic            fetch_reg, fetch_next;
  logic            seen_reg, seen_next;
  logic            init_reg, init_next;
  logic            start_reg, start_next;
  logic            load_reg, load_next;
  logic            valid_reg, valid_next;
  logic [BW-1:0]   hash_reg, hash_next;
`ifdef CUBEHASH_MSG_LEN_EN
  logic [63:0]     len_reg, len_next;
`endif

  logic [31:0]     word_in;
  logic [2:0]      word_bytes;

  // Last word keeps its valid bytes, gets the pad byte next, and is zero beyond.
  always_comb begin
    word_in    = in_data;
    word_bytes = 3'd4;
    if (in_last) begin
      case (in_bytes)
        2'd1:    begin word_in = {in_data[31:24], PAD_BYTE, 16'h0}; word_bytes = 3'd1; end
        2'd2:    begin word_in = {in_data[31:16], PAD_BYTE, 8'h0};  word_bytes = 3'd2; end
        2'd3:    begin word_in = {in_data[31:8],  PAD_BYTE};        word_bytes = 3'd3; end
        default: begin word_in = in_data;                           word_bytes = 3'd4; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wait_reg  <= 1'b0;
      buf_reg   <= '0;
      final_reg <= 1'b0;
      pad_reg   <= 1'b0;
      fetch_reg <= 1'b0;
      seen_reg  <= 1'b0;
      init_reg  <= 1'b0;
      start_reg <= 1'b0;
      load_reg  <= 1'b0;
      valid_reg <= 1'b0;
      hash_reg  <= '0;
`ifdef CUBEHASH_MSG_LEN_EN
      len_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= wait_next;
      buf_reg   <= buf_next;
      final_reg <= final_next;
      pad_reg   <= pad_next;
      fetch_reg <= fetch_next;
      seen_reg  <= seen_next;
      init_reg  <= init_next;
      start_reg <= start_next;
      load_reg  <= load_next;
      valid_reg <= valid_next;
      hash_reg  <= hash_next;
`ifdef CUBEHASH_MSG_LEN_EN
      len_reg   <= len_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wait_next  = wait_reg;
    buf_next   = buf_reg;
    final_next = final_reg;
    pad_next   = pad_reg;
    fetch_next = fetch_reg;
    seen_next  = seen_reg;
    init_next  = 1'b0;
    start_next = 1'b0;
    load_next  = 1'b0;
    valid_next = valid_reg;
    hash_next  = hash_reg;
`ifdef CUBEHASH_MSG_LEN_EN
    len_next   = len_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          init_next  = 1'b1;
          wait_next  = 1'b0;
          cnt_next   = '0;
          buf_next   = '0;
          final_next = 1'b0;
          pad_next   = 1'b0;
`ifdef CUBEHASH_MSG_LEN_EN
          len_next   = '0;
`endif
          state_next = INIT_W;
        end
      end
      INIT_W: begin
        // Core latches init, then loads the IV a cycle later; stay clear of both.
        wait_next = 1'b1;
        if (wait_reg) state_next = FILL;
      end
      FILL: begin
        if (in_valid) begin
          for (int i = 0; i < WORDS; i++) begin
            if (int'(cnt_reg) == i)
              buf_next[BW-1-32*i -: 32] = word_in;
            else if (in_last && in_bytes == 2'd0 && int'(cnt_reg) + 1 == i)
              buf_next[BW-1-32*i -: 32] = {PAD_BYTE, 24'h0};
          end
`ifdef CUBEHASH_MSG_LEN_EN
          len_next = len_reg + 64'(word_bytes);
`endif
          if (in_last) begin
            if (in_bytes == 2'd0 && cnt_reg == CW'(WORDS-1)) pad_next   = 1'b1;
            else                                               final_next = 1'b1;
            state_next = ISSUE;
          end else if (cnt_reg == CW'(WORDS-1)) begin
            state_next = ISSUE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!core_busy) begin
          start_next = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // Busy only rises the cycle after the start pulse, so ignore that cycle.
        if (!start_reg && !core_busy) begin
          if (pad_reg) begin
            buf_next   = {PAD_BYTE, {(BW-8){1'b0}}};
            pad_next   = 1'b0;
            final_next = 1'b1;
            state_next = ISSUE;
          end else if (final_reg) begin
            fetch_next = 1'b1;
            seen_next  = 1'b0;
            state_next = FINAL;
          end else begin
            buf_next   = '0;
            cnt_next   = '0;
            state_next = FILL;
          end
        end
      end
      FINAL: begin
        if (core_busy) seen_next = 1'b1;
        if (seen_reg && !core_busy) begin
          hash_next  = core_hash;
          valid_next = 1'b1;
          fetch_next = 1'b0;
          load_next  = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready   = (state_reg == FILL);
  assign core_init  = init_reg;
  assign core_start = start_reg;
  assign core_msg   = buf_reg;
  assign core_fetch = fetch_reg;
  assign core_load  = load_reg;
  assign out_valid  = valid_reg;
  assign out_hash   = hash_reg;
`ifdef CUBEHASH_MSG_LEN_EN
  assign msg_len    = len_reg;
`endif
endmodule

// File: tb/tb_cubehash_msg_ctrl.sv
// Directed bench for cubehash_msg_ctrl with a behavioural core stand-in.
// The stand-in's digest is a fixed pattern XORed with the number of absorbed blocks.
module tb_cubehash_msg_ctrl;
  localparam logic [255:0] HBASE =
    256'h0123456789abcdeffedcba9876543210_a5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [1:0]   in_bytes = '0;
  logic         core_init, core_start, core_fetch, core_load;
  logic [255:0] core_msg;
  logic         core_busy;
  logic [255:0] core_hash;
  logic         out_valid;
  logic [255:0] out_hash;
  logic         out_ready = 1'b0;
`ifdef CUBEHASH_MSG_LEN_EN
  logic [63:0]  msg_len;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cubehash_msg_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .core_init(core_init), .core_start(core_start), .core_msg(core_msg),
    .core_fetch(core_fetch), .core_load(core_load),
    .core_busy(core_busy), .core_hash(core_hash),
`ifdef CUBEHASH_MSG_LEN_EN
    .msg_len(msg_len),
`endif
    .out_valid(out_valid), .out_hash(out_hash), .out_ready(out_ready)
  );

  // Core stand-in: 4-cycle absorb per start, 10-cycle finalization on fetch.
  logic [255:0] blk [0:3];
  logic [255:0] msg_hold;
  int           nblk, stub_err, starts_at_fetch, n_init, busy_cnt;
  logic         init_d, fin_started;

  assign core_busy = (busy_cnt != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nblk <= 0; stub_err <= 0; starts_at_fetch <= 0; n_init <= 0; busy_cnt <= 0;
      init_d <= 1'b0; fin_started <= 1'b0; core_hash <= '0; msg_hold <= '0;
      for (int i = 0; i < 4; i++) blk[i] <= '0;
    end else begin
      init_d <= core_init;
      if (core_init) begin
        n_init <= n_init + 1;
        nblk   <= 0;
      end
      if (core_start) begin
        if (init_d || core_init || busy_cnt != 0) stub_err <= stub_err + 1;
        if (nblk < 4) blk[nblk] <= core_msg;
        nblk     <= nblk + 1;
        busy_cnt <= 4;
        msg_hold <= core_msg;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (core_msg !== msg_hold) stub_err <= stub_err + 1;
        if (busy_cnt == 1 && fin_started) core_hash <= HBASE ^ 256'(nblk);
      end else if (core_fetch && !fin_started) begin
        fin_started     <= 1'b1;
        busy_cnt        <= 10;
        starts_at_fetch <= nblk;
      end
      if (core_load) fin_started <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int t;
    logic done;
    in_data = d; in_last = last; in_bytes = nb; in_valid = 1'b1;
    t = 0; done = 1'b0;
    while (!done && t < 300) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("send_word_accepted", 256'(done), 256'd1);
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_timeout", 256'(out_valid), 256'd1);
  endtask

  task automatic take_out();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_cleared", 256'(out_valid), 256'd0);
  endtask

  function automatic logic [31:0] wd(input int i);
    return 32'hA0B0C0D0 ^ (32'h01010101 * i);
  endfunction

  logic [255:0] exp_blk;
  logic [255:0] held_hash;
  int           init_before;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   256'(in_ready),   256'd0);
    check("rst_core_init",  256'(core_init),  256'd0);
    check("rst_core_start", 256'(core_start), 256'd0);
    check("rst_core_fetch", 256'(core_fetch), 256'd0);
    check("rst_core_load",  256'(core_load),  256'd0);
    check("rst_core_msg",   core_msg,         256'd0);
    check("rst_out_valid",  256'(out_valid),  256'd0);
    check("rst_out_hash",   out_hash,         256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // "abc": single padded block
    send_word(32'h61626300, 1'b1, 2'd3);
    wait_out();
    check("abc_starts", 256'(nblk), 256'd1);
    check("abc_block",  blk[0], {32'h61626380, 224'h0});
    check("abc_hash",   out_hash, HBASE ^ 256'd1);
    check("abc_fetch_dropped", 256'(core_fetch), 256'd0);
    check("abc_core_ok", 256'(stub_err), 256'd0);
`ifdef CUBEHASH_MSG_LEN_EN
    check("abc_msg_len", 256'(msg_len), 256'd3);
`endif
    take_out();
    $display("msg abc: starts=%0d hash=%h", nblk, out_hash);

    // "a" with junk in the invalid bytes
    send_word(32'h61ffffff, 1'b1, 2'd1);
    wait_out();
    check("a_block", blk[0], {32'h61800000, 224'h0});
    check("a_hash",  out_hash, HBASE ^ 256'd1);
    take_out();
    $display("msg a: starts=%0d", nblk);

    // 8 full words then a last full word: pad lands in slot 1 of block 2
    for (int i = 0; i < 8; i++) send_word(wd(i), 1'b0, 2'd0);
    send_word(32'hdeadbeef, 1'b1, 2'd0);
    wait_out();
    exp_blk = '0;
    for (int i = 0; i < 8; i++) exp_blk[255-32*i -: 32] = wd(i);
    check("nine_starts", 256'(nblk), 256'd2);
    check("nine_block0", blk[0], exp_blk);
    check("nine_block1", blk[1], {32'hdeadbeef, 32'h80000000, 192'h0});
    check("nine_hash",   out_hash, HBASE ^ 256'd2);
    take_out();
    $display("msg 9 words: starts=%0d", nblk);

    // Exactly 8 words: separate pad-only block, finalization after it
    for (int i = 0; i < 7; i++) send_word(wd(i), 1'b0, 2'd0);
    send_word(wd(7), 1'b1, 2'd0);
    wait_out();
    check("eight_starts",    256'(nblk), 256'd2);
    check("eight_block0",    blk[0], exp_blk);
    check("eight_block1",    blk[1], {32'h80000000, 224'h0});
    check("eight_fetch_after_pad", 256'(starts_at_fetch), 256'd2);
    check("eight_core_ok",   256'(stub_err), 256'd0);
    take_out();
    $display("msg 8 words: starts=%0d", nblk);

    // 9 words, last with 2 bytes -> 34 bytes
    for (int i = 0; i < 8; i++) send_word(wd(i), 1'b0, 2'd0);
    send_word(32'h55667788, 1'b1, 2'd2);
    wait_out();
    check("len34_block1", blk[1], {32'h55668000, 224'h0});
`ifdef CUBEHASH_MSG_LEN_EN
    check("len34_msg_len", 256'(msg_len), 256'd34);
`endif
    take_out();
    $display("msg 34 bytes: starts=%0d", nblk);

    // Back-pressure on the output: 20 cycles with out_ready low and in_valid high
    send_word(32'h78797a00, 1'b1, 2'd3);
    wait_out();
    held_hash   = out_hash;
    init_before = n_init;
    in_valid = 1'b1; in_data = 32'h11111111;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_hash",     out_hash, held_hash);
      check("hold_valid",    256'(out_valid), 256'd1);
      check("hold_in_ready", 256'(in_ready),  256'd0);
    end
    check("hold_no_init", 256'(n_init), 256'(init_before));
    check("hold_hash_val", held_hash, HBASE ^ 256'd1);
    in_valid = 1'b0;
    take_out();
    $display("msg xyz: held 20 cycles hash=%h", held_hash);

    // Reset during finalization, then "abc" again
    in_data = 32'h61626300; in_last = 1'b1; in_bytes = 2'd3; in_valid = 1'b1;
    begin
      int t;
      t = 0;
      while (core_fetch !== 1'b1 && t < 300) begin
        @(negedge clk);
        if (in_ready) begin
          @(posedge clk); #1;
          in_valid = 1'b0; in_last = 1'b0;
        end
        t++;
      end
      check("final_reached", 256'(core_fetch), 256'd1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_fetch",    256'(core_fetch), 256'd0);
    check("midrst_valid",    256'(out_valid),  256'd0);
    check("midrst_out_hash", out_hash,         256'd0);
    check("midrst_core_msg", core_msg,         256'd0);
    check("midrst_in_ready", 256'(in_ready),   256'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    send_word(32'h61626300, 1'b1, 2'd3);
    wait_out();
    check("post_rst_inits", 256'(n_init), 256'd1);
    check("post_rst_block", blk[0], {32'h61626380, 224'h0});
    check("post_rst_hash",  out_hash, HBASE ^ 256'd1);
    check("post_rst_core_ok", 256'(stub_err), 256'd0);
    take_out();
    $display("msg abc after reset: starts=%0d", nblk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
